// File: rtl/alib_range_image_pkg.sv
// Shared definitions for the range-image library: FSM state encoding,
// point field width and the default "no return" pixel value.
package alib_range_image_pkg;

  localparam int          PT_W          = 16;
  localparam logic [15:0] EMPTY_VAL_DEF = 16'hFFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_FETCH   = 3'd3;
  localparam logic [2:0] ST_LOOKUP  = 3'd4;
  localparam logic [2:0] ST_COMPARE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CLEAR   = ST_CLEAR,
    S_RUN     = ST_RUN,
    S_FETCH   = ST_FETCH,
    S_LOOKUP  = ST_LOOKUP,
    S_COMPARE = ST_COMPARE,
    S_DONE    = ST_DONE
  } ri_state_t;

endpackage

// File: rtl/alib_ri_addr_gen.sv
// Pixel address generator: bounds check of (h, v) and linear address
// v*IMG_WIDTH + h. Shared by the writer and reader stages.
module alib_ri_addr_gen
  import alib_range_image_pkg::*;
#(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 64,
  parameter int ADDR_W     = 16
) (
  input  logic [PT_W-1:0]   h,
  input  logic [PT_W-1:0]   v,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  localparam logic [31:0]     W32 = 32'(IMG_WIDTH);
  localparam logic [31:0]     H32 = 32'(IMG_HEIGHT);
  localparam logic [ADDR_W:0] W_A = (ADDR_W + 1)'(IMG_WIDTH);

  logic [ADDR_W:0] lin;

  // One guard bit so an address that would not fit ADDR_W is rejected, not aliased.
  always_comb begin
    lin      = (ADDR_W + 1)'(v) * W_A + (ADDR_W + 1)'(h);
    in_range = ({16'b0, h} < W32) && ({16'b0, v} < H32) && !lin[ADDR_W];
    addr     = lin[ADDR_W-1:0];
  end

endmodule

// File: rtl/alib_range_image_writer.sv
// Range-image writer: clears the image at frame start, then keeps the
// nearest return per pixel via read-compare-write on a single-port memory.
module alib_range_image_writer
  import alib_range_image_pkg::*;
#(
  parameter int              IMG_WIDTH  = 1024,
  parameter int              IMG_HEIGHT = 64,
  parameter int              ADDR_W     = 16,
  parameter logic [PT_W-1:0] EMPTY_VAL  = EMPTY_VAL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [PT_W-1:0]   point_h_in,
  input  logic [PT_W-1:0]   point_v_in,
  input  logic [PT_W-1:0]   point_r_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [PT_W-1:0]   mem_wr_data,
  input  logic [PT_W-1:0]   mem_rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       points_written,
  output logic [31:0]       points_dropped
);

  localparam int                NPIX     = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  ri_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [PT_W-1:0]   r_q;
  logic              end_flag;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_in_range;
  logic              drop;
  logic              closer;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  alib_ri_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .h       (point_h_in),
    .v       (point_v_in),
    .addr    (gen_addr),
    .in_range(gen_in_range)
  );

  assign drop     = !gen_in_range || (point_r_in == '0);
  assign closer   = r_q < mem_rd_data;
  assign mem_addr = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    busy        = (state != S_IDLE);
    frame_done  = 1'b0;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        mem_wr_en   = 1'b1;
        mem_wr_data = EMPTY_VAL;
        if (addr_q == LAST_PIX) state_nxt = S_RUN;
      end
      // Draining the FIFO always wins over finishing the frame.
      S_RUN: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = S_FETCH;
        end else if (end_flag) begin
          state_nxt = S_DONE;
        end
      end
      S_FETCH:   state_nxt = drop ? S_RUN : S_LOOKUP;
      S_LOOKUP:  state_nxt = S_COMPARE;
      S_COMPARE: begin
        if (closer) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = r_q;
        end
        state_nxt = S_RUN;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address counter, latched point, frame-end flag and statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q         <= '0;
      r_q            <= '0;
      end_flag       <= 1'b0;
      points_written <= '0;
      points_dropped <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (frame_start) begin
          addr_q         <= '0;
          end_flag       <= 1'b0;
          points_written <= '0;
          points_dropped <= '0;
        end
      end else if (frame_end) begin
        end_flag <= 1'b1;
      end
      case (state)
        S_CLEAR: if (addr_q != LAST_PIX) addr_q <= addr_q + 1'b1;
        S_FETCH: begin
          if (drop) begin
            points_dropped <= sat_inc(points_dropped);
          end else begin
            addr_q <= gen_addr;
            r_q    <= point_r_in;
          end
        end
        S_COMPARE: if (closer) points_written <= sat_inc(points_written);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alib_range_image_writer.sv
// Self-checking bench for alib_range_image_writer on an 8x4 image with a
// behavioural FIFO, 1-cycle memory and a nearest-return image model.
module tb_alib_range_image_writer;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int AW   = 16;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [15:0]   point_h_in, point_v_in, point_r_in;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [15:0]   mem_wr_data;
  logic [15:0]   mem_rd_data;
  logic          busy;
  logic          frame_done;
  logic [31:0]   points_written;
  logic [31:0]   points_dropped;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alib_range_image_writer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .point_h_in    (point_h_in),
    .point_v_in    (point_v_in),
    .point_r_in    (point_r_in),
    .mem_addr      (mem_addr),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .points_written(points_written),
    .points_dropped(points_dropped)
  );

  // Single-port memory, 1-cycle read latency
  logic [15:0] mem [0:NPIX-1];
  logic        scramble = 1'b0;
  int          bad_wr_addr = 0;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= 16'h1234 + 16'(i);
    end else if (mem_wr_en) begin
      if (mem_addr < 16'(NPIX)) mem[mem_addr[4:0]] <= mem_wr_data;
      else bad_wr_addr <= bad_wr_addr + 1;
    end
    mem_rd_data <= (mem_addr < 16'(NPIX)) ? mem[mem_addr[4:0]] : 16'h0000;
  end

  // Upstream FIFO: data appears the cycle after a pop
  logic [15:0] fh [0:255];
  logic [15:0] fv [0:255];
  logic [15:0] fr [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      point_h_in <= fh[rd_ptr[7:0]];
      point_v_in <= fv[rd_ptr[7:0]];
      point_r_in <= fr[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [15:0] h, input logic [15:0] v, input logic [15:0] r);
    fh[wr_ptr[7:0]] = h;
    fv[wr_ptr[7:0]] = v;
    fr[wr_ptr[7:0]] = r;
    wr_ptr = wr_ptr + 1;
  endtask

  // Event monitor, sampled mid-cycle
  int          cyc = 0;
  int          pop_q[$];
  int          n_wr = 0;
  int          n_done = 0;
  int          proto_err = 0;
  int          last_wr_cyc = 0;
  logic [15:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic        prev_rd = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(negedge clk);
    #2;
    if (fifo_rd_en) begin
      if (fifo_empty || prev_rd) proto_err <= proto_err + 1;
      pop_q.push_back(cyc);
    end
    prev_rd <= fifo_rd_en;
    if (mem_wr_en) begin
      n_wr         <= n_wr + 1;
      last_wr_cyc  <= cyc;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wr_data;
    end
    if (frame_done) begin
      n_done <= n_done + 1;
      if (!fifo_empty) proto_err <= proto_err + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  // Starts a frame and checks every clear cycle; end_at >= 0 pulses frame_end in that clear cycle
  task automatic start_and_check_clear(input int end_at);
    int bad;
    bad = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      #1;
      if (!(mem_wr_en && mem_addr == 16'(i) && mem_wr_data == 16'hFFFF && busy && !fifo_rd_en))
        bad++;
      frame_end = (i == end_at);
      @(negedge clk);
    end
    frame_end = 1'b0;
    #1;
    chk("clear_cycles_bad", bad, 0);
    chk("clear_then_no_write", {31'b0, mem_wr_en}, 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout_busy", {31'b0, busy}, 0);
  endtask

  typedef struct {
    logic [15:0] h, v, r;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic        exp_drop;
  } vec_t;

  vec_t        tbl [10];
  logic [15:0] ref_img [0:NPIX-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int w0, d0, nw0, np0, dn0, exp_w, exp_d, idx, k;
    logic [15:0] h, v, r;

    tbl[0] = '{16'd3,     16'd2, 16'd500,   1'b1, 16'd19, 1'b0};
    tbl[1] = '{16'd3,     16'd2, 16'd400,   1'b1, 16'd19, 1'b0};
    tbl[2] = '{16'd3,     16'd2, 16'd700,   1'b0, 16'd0,  1'b0};
    tbl[3] = '{16'd8,     16'd0, 16'd10,    1'b0, 16'd0,  1'b1};
    tbl[4] = '{16'd0,     16'd4, 16'd10,    1'b0, 16'd0,  1'b1};
    tbl[5] = '{16'd1,     16'd1, 16'd0,     1'b0, 16'd0,  1'b1};
    tbl[6] = '{16'd7,     16'd3, 16'd1,     1'b1, 16'd31, 1'b0};
    tbl[7] = '{16'd0,     16'd0, 16'd65534, 1'b1, 16'd0,  1'b0};
    tbl[8] = '{16'd0,     16'd0, 16'd65535, 1'b0, 16'd0,  1'b0};
    tbl[9] = '{16'd65535, 16'd0, 16'd5,     1'b0, 16'd0,  1'b1};

    // Reset state
    tick(2);
    scramble = 1'b1;
    tick(1);
    scramble = 1'b0;
    #1;
    chk("rst_fifo_rd_en", {31'b0, fifo_rd_en}, 0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    chk("rst_mem_wr_data", {16'b0, mem_wr_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    chk("rst_points_written", points_written, 0);
    chk("rst_points_dropped", points_dropped, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // Frame 1: table of single points
    start_and_check_clear(-1);
    for (int i = 0; i < 10; i++) begin
      w0  = points_written;
      d0  = points_dropped;
      nw0 = n_wr;
      np0 = pop_q.size();
      push(tbl[i].h, tbl[i].v, tbl[i].r);
      tick(7);
      chk($sformatf("vec%0d_pops", i), pop_q.size() - np0, 1);
      chk($sformatf("vec%0d_writes", i), n_wr - nw0, {31'b0, tbl[i].exp_wr});
      chk($sformatf("vec%0d_written", i), points_written - w0, {31'b0, tbl[i].exp_wr});
      chk($sformatf("vec%0d_dropped", i), points_dropped - d0, {31'b0, tbl[i].exp_drop});
      if (tbl[i].exp_wr && n_wr != nw0 && pop_q.size() > np0) begin
        chk($sformatf("vec%0d_wr_addr", i), {16'b0, last_wr_addr}, {16'b0, tbl[i].exp_addr});
        chk($sformatf("vec%0d_wr_data", i), {16'b0, last_wr_data}, {16'b0, tbl[i].r});
        chk($sformatf("vec%0d_pop_to_write", i), last_wr_cyc - pop_q[pop_q.size()-1], 3);
      end
    end
    chk("pixel19", {16'b0, mem[19]}, 400);
    chk("pixel31", {16'b0, mem[31]}, 1);
    chk("f1_written", points_written, 4);
    chk("f1_dropped", points_dropped, 4);

    // Back-to-back points: stored takes 4 cycles, dropped takes 2
    np0 = pop_q.size();
    push(16'd1, 16'd0, 16'd10);
    push(16'd9, 16'd0, 16'd1);
    push(16'd2, 16'd0, 16'd10);
    tick(14);
    chk("burst_pops", pop_q.size() - np0, 3);
    if (pop_q.size() - np0 == 3) begin
      chk("burst_stored_gap", pop_q[np0+1] - pop_q[np0], 4);
      chk("burst_dropped_gap", pop_q[np0+2] - pop_q[np0+1], 2);
    end
    dn0 = n_done;
    pulse_end();
    wait_idle();
    tick(2);
    chk("f1_done_pulses", n_done - dn0, 1);

    // Frame 2: frame_end during clear with three points queued
    push(16'd4, 16'd1, 16'd100);
    push(16'd5, 16'd2, 16'd200);
    push(16'd6, 16'd3, 16'd300);
    dn0 = n_done;
    np0 = pop_q.size();
    start_and_check_clear(5);
    wait_idle();
    tick(3);
    chk("f2_done_pulses", n_done - dn0, 1);
    chk("f2_pops", pop_q.size() - np0, 3);
    chk("f2_written", points_written, 3);
    chk("f2_dropped", points_dropped, 0);
    chk("f2_busy_low", {31'b0, busy}, 0);
    chk("f2_pixel30", {16'b0, mem[30]}, 300);

    // Frame 3: random points against the nearest-return model
    for (int i = 0; i < NPIX; i++) ref_img[i] = 16'hFFFF;
    exp_w = 0;
    exp_d = 0;
    start_and_check_clear(-1);
    for (int i = 0; i < 60; i++) begin
      h = 16'($urandom_range(0, 9));
      v = 16'($urandom_range(0, 5));
      r = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
      push(h, v, r);
      if (h < 16'(W) && v < 16'(H) && r != 16'd0) begin
        idx = int'(v) * W + int'(h);
        if (r < ref_img[idx]) begin
          ref_img[idx] = r;
          exp_w++;
        end
      end else begin
        exp_d++;
      end
      tick($urandom_range(0, 5));
    end
    dn0 = n_done;
    pulse_end();
    wait_idle();
    tick(2);
    chk("f3_done_pulses", n_done - dn0, 1);
    chk("f3_written", points_written, exp_w);
    chk("f3_dropped", points_dropped, exp_d);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("f3_pixel%0d", i), {16'b0, mem[i]}, {16'b0, ref_img[i]});

    // Frame 4: reset during COMPARE, then restart
    start_and_check_clear(-1);
    push(16'd5, 16'd1, 16'd77);
    #1;
    k = 0;
    while (!fifo_rd_en && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("f4_pop_seen", {31'b0, fifo_rd_en}, 1);
    tick(3);
    #1;
    chk("f4_compare_wr_en", {31'b0, mem_wr_en}, 1);
    chk("f4_compare_addr", {16'b0, mem_addr}, 13);
    rst = 1'b0;
    #1;
    chk("f4_rst_wr_en", {31'b0, mem_wr_en}, 0);
    chk("f4_rst_addr", {16'b0, mem_addr}, 0);
    chk("f4_rst_wr_data", {16'b0, mem_wr_data}, 0);
    chk("f4_rst_busy", {31'b0, busy}, 0);
    chk("f4_rst_rd_en", {31'b0, fifo_rd_en}, 0);
    chk("f4_rst_written", points_written, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    start_and_check_clear(-1);
    dn0 = n_done;
    pulse_end();
    wait_idle();
    tick(2);
    chk("f4_done_pulses", n_done - dn0, 1);

    chk("protocol_errors", proto_err, 0);
    chk("out_of_range_writes", bad_wr_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
